glbl_rst_seq: RTL and testbench

Reset release sequencer that consumes the global reset-control register bits and drives the per-block active-low resets. Software or power-up writes a request vector; the sequencer asserts resets immediately but releases them one at a time in ascending bit order. Each release honours a minimum assertion width and a fixed gap between consecutive releases. It sits between the pinmux global reset register and the reset inputs of the core, peripherals and memories.

---
 rtl/glbl_rst_seq.sv | 203 ++++++++++++++++++++
 tb/tb_glbl_rst_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/glbl_rst_seq.sv
// Reset release sequencer: resets are asserted at once, but released one domain at a
// time in ascending bit order, each after a minimum low time and with a gap between releases.
module glbl_rst_seq #(
    parameter int NUM_RST    = 8,
    parameter int MIN_ASSERT = 16,
    parameter int GAP_CYC    = 4
) (
    input  logic               clk,
    input  logic               s_reset_n,
    input  logic [NUM_RST-1:0] rst_req,
    input  logic               force_rst,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               busy,
    output logic               rel_pulse
);

    localparam int AW = $clog2(MIN_ASSERT + 1);
    localparam int SW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(MIN_ASSERT);
    localparam logic [7:0]    GAP_VAL = 8'(GAP_CYC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_AGE = 2'd1,
        GAP      = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SW-1:0]      sel_r;
    logic [SW-1:0]      sel_nxt_s;
    logic [7:0]         gcnt_r;
    logic [7:0]         gcnt_nxt_s;
    logic [NUM_RST-1:0] rst_n_out_r;
    logic [NUM_RST-1:0] rst_n_nxt_s;
    logic [AW-1:0]      age_r     [NUM_RST];
    logic [AW-1:0]      age_nxt_s [NUM_RST];
    logic [NUM_RST-1:0] assert_s;
    logic [NUM_RST-1:0] pending_s;
    logic [NUM_RST-1:0] rel_vec_s;
    logic               release_s;
    logic               release_d_r;
    logic               rel_pulse_r;
    logic               busy_r;
    logic               busy_nxt_s;

    // Saturating increment of a per-domain age counter.
    function automatic logic [AW-1:0] age_inc(input logic [AW-1:0] age);
        logic [AW-1:0] res;
        if (age == AGE_MAX) begin
            res = AGE_MAX;
        end else begin
            res = age + AW'(1);
        end
        return res;
    endfunction

    // Index of the lowest set bit; scanning downwards lets the lowest hit win.
    function automatic logic [SW-1:0] lowest_idx(input logic [NUM_RST-1:0] vec);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = NUM_RST - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign assert_s  = ~rst_req | {NUM_RST{force_rst}};
    assign pending_s = rst_req & ~rst_n_out_r & {NUM_RST{~force_rst}};

    // Release decision, per-bit release strobe and next busy level.
    always_comb begin
        release_s = 1'b0;
        rel_vec_s = '0;
        if ((state_r == WAIT_AGE) && !force_rst && rst_req[sel_r] && (age_r[sel_r] == AGE_MAX)) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end
        for (int i = 0; i < NUM_RST; i++) begin
            rel_vec_s[i] = release_s && (sel_r == SW'(i));
        end
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        gcnt_nxt_s  = gcnt_r;
        case (state_r)
            IDLE: begin
                if (|pending_s) begin
                    sel_nxt_s   = lowest_idx(pending_s);
                    state_nxt_s = WAIT_AGE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_AGE: begin
                if (force_rst || !rst_req[sel_r]) begin
                    state_nxt_s = IDLE;
                end else if (release_s) begin
                    if (GAP_CYC == 0) begin
                        state_nxt_s = IDLE;
                    end else begin
                        gcnt_nxt_s  = GAP_VAL;
                        state_nxt_s = GAP;
                    end
                end else begin
                    state_nxt_s = WAIT_AGE;
                end
            end
            GAP: begin
                // A count of 0 can only come from a corrupted register; leave rather than wrap.
                if (force_rst || (gcnt_r <= 8'd1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    gcnt_nxt_s  = gcnt_r - 8'd1;
                    state_nxt_s = GAP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Per-domain next reset level and age: assertion always beats release.
    always_comb begin
        rst_n_nxt_s = rst_n_out_r;
        for (int i = 0; i < NUM_RST; i++) begin
            age_nxt_s[i] = age_r[i];
            if (assert_s[i]) begin
                rst_n_nxt_s[i] = 1'b0;
                if (rst_n_out_r[i]) begin
                    age_nxt_s[i] = '0;
                end else begin
                    age_nxt_s[i] = age_inc(age_r[i]);
                end
            end else if (rel_vec_s[i]) begin
                rst_n_nxt_s[i] = 1'b1;
                age_nxt_s[i]   = '0;
            end else if (!rst_n_out_r[i]) begin
                rst_n_nxt_s[i] = 1'b0;
                age_nxt_s[i]   = age_inc(age_r[i]);
            end else begin
                rst_n_nxt_s[i] = 1'b1;
                age_nxt_s[i]   = '0;
            end
        end
    end

    // FSM state, selected domain and gap counter.
    always_ff @(posedge clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            state_r <= IDLE;
            sel_r   <= '0;
            gcnt_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            gcnt_r  <= gcnt_nxt_s;
        end
    end

    // Reset outputs and age counters.
    always_ff @(posedge clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            rst_n_out_r <= '0;
            for (int i = 0; i < NUM_RST; i++) begin
                age_r[i] <= '0;
            end
        end else begin
            rst_n_out_r <= rst_n_nxt_s;
            for (int i = 0; i < NUM_RST; i++) begin
                age_r[i] <= age_nxt_s[i];
            end
        end
    end

    // Status outputs; rel_pulse lags the release edge by one cycle.
    always_ff @(posedge clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            busy_r      <= 1'b0;
            release_d_r <= 1'b0;
            rel_pulse_r <= 1'b0;
        end else begin
            busy_r      <= busy_nxt_s;
            release_d_r <= release_s;
            rel_pulse_r <= release_d_r;
        end
    end

    assign rst_n_out = rst_n_out_r;
    assign busy      = busy_r;
    assign rel_pulse = rel_pulse_r;

endmodule

// File: tb/tb_glbl_rst_seq.sv
// Directed bench for glbl_rst_seq: instance a (4/16/4) and instance b (4/4/0, no gap),
// outputs sampled 1 time unit after each rising edge, edges counted from reset release.
module tb_glbl_rst_seq;

    logic       clk;
    logic       rst_n_a, force_a, busy_a, pulse_a;
    logic [3:0] req_a, out_a;
    logic       rst_n_b, force_b, busy_b, pulse_b;
    logic [3:0] req_b, out_b;

    int cyc;
    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    glbl_rst_seq #(.NUM_RST(4), .MIN_ASSERT(16), .GAP_CYC(4)) dut_a (
        .clk(clk), .s_reset_n(rst_n_a), .rst_req(req_a), .force_rst(force_a),
        .rst_n_out(out_a), .busy(busy_a), .rel_pulse(pulse_a)
    );

    glbl_rst_seq #(.NUM_RST(4), .MIN_ASSERT(4), .GAP_CYC(0)) dut_b (
        .clk(clk), .s_reset_n(rst_n_b), .rst_req(req_b), .force_rst(force_b),
        .rst_n_out(out_b), .busy(busy_b), .rel_pulse(pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after edge t (t counted from the last reset release).
    task automatic goto(input int t);
        int n;
        n = t - cyc;
        repeat (n) @(posedge clk);
        cyc = t;
        #1;
    endtask

    // Release rst_n_a after the next edge (edge 0) with req_a=F and check the power-up sequence.
    task automatic seq_from_reset(input string tag);
        @(posedge clk);
        #1;
        cyc = 0;
        rst_n_a = 1'b1;
        goto(1);  chk({tag, "_busy1"},  32'(busy_a),  32'h1);
        goto(16); chk({tag, "_out16"},  32'(out_a),   32'h0);
        goto(17); chk({tag, "_out17"},  32'(out_a),   32'h1);
                  chk({tag, "_pls17"},  32'(pulse_a), 32'h0);
        goto(18); chk({tag, "_pls18"},  32'(pulse_a), 32'h1);
        goto(19); chk({tag, "_pls19"},  32'(pulse_a), 32'h0);
        goto(22); chk({tag, "_out22"},  32'(out_a),   32'h1);
        goto(23); chk({tag, "_out23"},  32'(out_a),   32'h3);
        goto(24); chk({tag, "_pls24"},  32'(pulse_a), 32'h1);
        goto(29); chk({tag, "_out29"},  32'(out_a),   32'h7);
        goto(30); chk({tag, "_pls30"},  32'(pulse_a), 32'h1);
        goto(35); chk({tag, "_out35"},  32'(out_a),   32'hF);
        goto(36); chk({tag, "_pls36"},  32'(pulse_a), 32'h1);
                  chk({tag, "_busy36"}, 32'(busy_a),  32'h1);
        goto(39); chk({tag, "_busy39"}, 32'(busy_a),  32'h0);
    endtask

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        cyc       = 0;
        rst_n_a   = 1'b0;
        rst_n_b   = 1'b0;
        req_a     = 4'h0;
        req_b     = 4'h0;
        force_a   = 1'b0;
        force_b   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_a",   32'(out_a),   32'h0);
        chk("rst_busy_a",  32'(busy_a),  32'h0);
        chk("rst_pulse_a", 32'(pulse_a), 32'h0);
        chk("rst_out_b",   32'(out_b),   32'h0);

        // b: bit 1 withdrawn during WAIT_AGE, then gapless release of all bits
        cyc = 0;
        rst_n_b = 1'b1;
        req_b = 4'h2;
        goto(1);  chk("b_busy1",  32'(busy_b),  32'h1);
        goto(2);  req_b = 4'h0;
        goto(3);  chk("b_busy3",  32'(busy_b),  32'h0);
        goto(5);  chk("b_out5",   32'(out_b),   32'h0);
        goto(6);  chk("b_pls6",   32'(pulse_b), 32'h0);
                  chk("b_out6",   32'(out_b),   32'h0);
                  req_b = 4'hF;
        goto(8);  chk("b_out8",   32'(out_b),   32'h1);
        goto(9);  chk("b_out9",   32'(out_b),   32'h1);
                  chk("b_pls9",   32'(pulse_b), 32'h1);
        goto(10); chk("b_out10",  32'(out_b),   32'h3);
                  chk("b_pls10",  32'(pulse_b), 32'h0);
        goto(12); chk("b_out12",  32'(out_b),   32'h7);
        goto(14); chk("b_out14",  32'(out_b),   32'hF);
        goto(15); chk("b_pls15",  32'(pulse_b), 32'h1);
                  chk("b_busy15", 32'(busy_b),  32'h0);

        // a: power-up sequence
        req_a = 4'hF;
        seq_from_reset("pwr");

        // a: single-bit withdraw and restore
        goto(49); req_a = 4'hB;
        goto(50); chk("wd_out50",  32'(out_a),   32'hB);
                  req_a = 4'hF;
        goto(51); chk("wd_out51",  32'(out_a),   32'hB);
                  chk("wd_busy51", 32'(busy_a),  32'h1);
        goto(66); chk("wd_out66",  32'(out_a),   32'hB);
        goto(67); chk("wd_out67",  32'(out_a),   32'hF);
        goto(68); chk("wd_pls68",  32'(pulse_a), 32'h1);

        // a: one-cycle force_rst
        goto(80);  force_a = 1'b1;
        goto(81);  chk("frc_out81",  32'(out_a), 32'h0);
                   force_a = 1'b0;
        goto(97);  chk("frc_out97",  32'(out_a), 32'h0);
        goto(98);  chk("frc_out98",  32'(out_a), 32'h1);
        goto(104); chk("frc_out104", 32'(out_a), 32'h3);
        goto(110); chk("frc_out110", 32'(out_a), 32'h7);
        goto(116); chk("frc_out116", 32'(out_a), 32'hF);
        goto(117); chk("frc_pls117", 32'(pulse_a), 32'h1);
        goto(120); chk("frc_busy120", 32'(busy_a), 32'h0);

        // a: bit 3 latched first, bit 0 picked at the next IDLE
        goto(125); req_a = 4'h0;
        goto(126); chk("ord_out126", 32'(out_a),   32'h0);
        goto(150); req_a = 4'h8;
        goto(152); chk("ord_out152", 32'(out_a),   32'h8);
                   req_a = 4'h9;
        goto(153); chk("ord_pls153", 32'(pulse_a), 32'h1);
        goto(157); chk("ord_out157", 32'(out_a),   32'h8);
        goto(158); chk("ord_out158", 32'(out_a),   32'h9);
        goto(159); chk("ord_pls159", 32'(pulse_a), 32'h1);

        // a: asynchronous reset during GAP, then a clean restart
        goto(160);
        #2;
        rst_n_a = 1'b0;
        #1;
        chk("ar_out",   32'(out_a),   32'h0);
        chk("ar_busy",  32'(busy_a),  32'h0);
        chk("ar_pulse", 32'(pulse_a), 32'h0);
        req_a = 4'hF;
        seq_from_reset("rst2");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
